hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It compares register addresses and control bits already carried through the decode→execute→memory→writeback control registers (reg_wr, rd, cs, wb_sel, br_taken) and drives stall, flush and forwarding-select signals for the pipeline registers. It also freezes the pipeline while data memory is busy and flushes the control-only pipeline registers after reset. Saturating stall and flush counters support performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.
- INIT_CYC, 2, number of post-reset cycles spent flushing the pipeline.

Ports:
- clk  in  1  core clock; every state element updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- rs1_D, rs2_D  in  5 each  source registers of the instruction in decode.
- rs1_E, rs2_E  in  5 each  source registers of the instruction in execute.
- rd_E, rd_M, rd_W  in  5 each  destination registers in E, M and W.
- reg_wrE, reg_wrM, reg_wrW  in  1 each  register-write enables per stage.
- rdE  in  1  execute-stage instruction is a load.
- csM  in  1  memory-stage instruction accesses data memory.
- br_takenE  in  1  branch or jump resolved taken in execute.
- dmem_ready  in  1  data memory has completed the current access.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the PC or the named pipeline register.
- flush_D, flush_E  out  1 each  load a bubble (all control bits 0) into the D or E register.
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 M result, 10 W result.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- FSM state is registered. States:
  - INIT: flush_D = flush_E = 1, stall_F = stall_D = 1, all other outputs 0. Lasts exactly INIT_CYC cycles after rst falls, then moves to RUN.
  - RUN: normal operation.
  - MWAIT: pipeline frozen while memory is busy.
- RUN → MWAIT when csM=1 and dmem_ready=0. MWAIT → RUN in the cycle after dmem_ready=1 is seen.
- Frozen means stall_F/D/E/M = 1 and no flush. This applies in MWAIT and in the RUN cycle that detects the miss (the freeze is combinational, not delayed).
- Forwarding for operand a (b is identical with rs2_E):
  - fwd_a = 01 if reg_wrM && rd_M≠0 && rd_M==rs1_E.
  - else 10 if reg_wrW && rd_W≠0 && rd_W==rs1_E.
  - else 00. M has priority over W.
- Load-use hazard: rdE && rd_E≠0 && (rd_E==rs1_D || rd_E==rs2_D). Response: stall_F = stall_D = 1 and flush_E = 1 for one cycle.
- Branch: br_takenE → flush_D = flush_E = 1, with stall_F = stall_D = 0 (the PC redirect must load).
- Priority in RUN: freeze > branch flush > load-use stall > forwarding. A branch is never lost under freeze: br_takenE stays held in the frozen E register and is acted on once the freeze releases.
- x0 is never a hazard or forwarding source.
- Counters:
  - stall_cnt increments in every cycle where stall_F=1 outside INIT.
  - flush_cnt increments once per branch flush.
  - Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and fwd outputs are combinational from the current inputs and registered state, with zero-cycle latency. The pipeline registers act on them at the next clk edge.
- A load-use stall lasts exactly 1 cycle: the load advances to M, and on the next cycle forwarding from W covers the dependency.
- A memory freeze lasts N+1 cycles for N cycles of dmem_ready=0.
- Reset: while rst=1, state = INIT, init count = 0, counters = 0. Outputs read as the INIT state: stall_F=1, stall_D=1, stall_E=0, stall_M=0, flush_D=1, flush_E=1, fwd_a=fwd_b=00.
- Reset asserted mid-MWAIT or mid-INIT restarts INIT in full; the count resets to 0.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined:
  - fwd_a = fwd_b = 00 at all times.
  - Any RAW match of rs1_D or rs2_D against a written, nonzero rd in E, M or W stalls F/D and flushes E, re-evaluated every cycle until the producer retires. This is up to 3 cycles.
  - The load-use rule is subsumed by this rule.
  - Counters, freeze, branch and INIT behaviour are unchanged.

## Test plan
- Reset: rst=1 for 3 cycles, then 0 → flush_D/flush_E=1 for exactly 2 cycles, then all outputs 0 and counters 0.
- Forward: reg_wrM=1, rd_M=5, rs1_E=5, reg_wrW=1, rd_W=5 → fwd_a=01. With rd_M=0 instead → fwd_a=10.
- Load-use: rdE=1, rd_E=7, rs2_D=7 → one cycle of stall_F=stall_D=flush_E=1, stall_cnt=1. With rd_E=0 → no stall.
- Branch during load-use: br_takenE=1 together with the load-use condition → flush_D=flush_E=1, stall_F=0, flush_cnt=1.
- Memory wait: csM=1, dmem_ready=0 for 3 cycles, then 1 → stall_F/D/E/M=1 for 4 cycles, no flush even with br_takenE=1. The flush fires on the release cycle.
- Without HAZARD_FWD_EN: reg_wrE=1, rd_E=3, rs1_D=3, instruction advancing normally → stall for 3 cycles (producer in E, M, then W), fwd_a stays 00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage RV32 pipeline.
// Define HAZARD_FWD_EN for operand forwarding; otherwise RAW hazards stall until the producer retires.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int INIT_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wrE,
  input  logic             reg_wrM,
  input  logic             reg_wrW,
  input  logic             rdE,
  input  logic             csM,
  input  logic             br_takenE,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {INIT, RUN, MWAIT} state_t;
  localparam int IW = $clog2(INIT_CYC + 2);
  state_t        st;
  logic [IW-1:0] icnt;
  logic          init, frz, brf, haz, lu;
  function automatic logic hit(input logic wr, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return wr && rd != 5'd0 && (rd == a || rd == b);
  endfunction
`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fsel(input logic [4:0] rs, input logic wm, input logic [4:0] dm,
                                      input logic ww, input logic [4:0] dw);
    return hit(wm, dm, rs, rs) ? 2'b01 : hit(ww, dw, rs, rs) ? 2'b10 : 2'b00;
  endfunction
  logic unused_nofwd;
  assign unused_nofwd = reg_wrE;
  assign haz   = hit(rdE, rd_E, rs1_D, rs2_D);
  assign fwd_a = init ? 2'b00 : fsel(rs1_E, reg_wrM, rd_M, reg_wrW, rd_W);
  assign fwd_b = init ? 2'b00 : fsel(rs2_E, reg_wrM, rd_M, reg_wrW, rd_W);
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_E, rs2_E, rdE};
  assign haz   = hit(reg_wrE, rd_E, rs1_D, rs2_D) || hit(reg_wrM, rd_M, rs1_D, rs2_D) ||
                 hit(reg_wrW, rd_W, rs1_D, rs2_D);
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif
  // The miss freezes in the very cycle it is detected, not one cycle later
  assign init    = st == INIT;
  assign frz     = st == MWAIT || (st == RUN && csM && !dmem_ready);
  assign brf     = st == RUN && !frz && br_takenE;
  assign lu      = st == RUN && !frz && !brf && haz;
  assign stall_F = init || frz || lu;
  assign stall_D = stall_F;
  assign stall_E = frz;
  assign stall_M = frz;
  assign flush_D = init || brf;
  assign flush_E = init || brf || lu;
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= INIT;
      icnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(stall_F && !init && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(brf && !(&flush_cnt));
      case (st)
        INIT: begin
          icnt <= icnt + IW'(1);
          st   <= (icnt == IW'(INIT_CYC - 1)) ? RUN : INIT;
        end
        RUN:     st <= (csM && !dmem_ready) ? MWAIT : RUN;
        MWAIT:   st <= dmem_ready ? RUN : MWAIT;
        default: st <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench comparing hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int CW  = 4;
  localparam int IC  = 2;
  localparam int MAX = (1 << CW) - 1;
  logic clk = 0;
  always #5 clk = ~clk;
  logic          rst;
  logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic          reg_wrE, reg_wrM, reg_wrW, rdE, csM, br_takenE, dmem_ready;
  logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CW), .INIT_CYC(IC)) dut (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .reg_wrE(reg_wrE), .reg_wrM(reg_wrM),
    .reg_wrW(reg_wrW), .rdE(rdE), .csM(csM), .br_takenE(br_takenE), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic [1:0]    fl;
    logic [3:0]    fw;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0;
  int   init_left = 0, sc = 0, fc = 0;
  bit   waiting = 0, valid = 0;

  function automatic bit hit(input logic wr, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return wr && rd != 0 && (rd == a || rd == b);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (hit(reg_wrM, rd_M, rs, rs)) return 2'b01;
    if (hit(reg_wrW, rd_W, rs, rs)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clr();
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {reg_wrE, reg_wrM, reg_wrW, rdE, csM, br_takenE} = '0;
    dmem_ready = 1;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model across the edge
  task automatic cyc();
    exp_t e;
    bit ini, frz, br, haz, s;
    if (valid) begin
      ini = init_left > 0;
      frz = !ini && (waiting || (csM && !dmem_ready));
      br  = !ini && !frz && br_takenE;
`ifdef HAZARD_FWD_EN
      haz = rdE && hit(1'b1, rd_E, rs1_D, rs2_D);
      e.fw = ini ? 4'b0 : {fsel(rs1_E), fsel(rs2_E)};
`else
      haz = hit(reg_wrE, rd_E, rs1_D, rs2_D) || hit(reg_wrM, rd_M, rs1_D, rs2_D) ||
            hit(reg_wrW, rd_W, rs1_D, rs2_D);
      e.fw = 4'b0;
`endif
      haz  = haz && !ini && !frz && !br;
      s    = ini || frz || haz;
      e.st = {s, s, frz, frz};
      e.fl = {ini || br, ini || br || haz};
      e.sc = CW'(sc);
      e.fc = CW'(fc);
      q.push_back(e);
      if (!rst) begin
        if (s && !ini && sc < MAX) sc++;
        if (br && fc < MAX) fc++;
        if (ini) init_left--;
        else waiting = waiting ? !dmem_ready : (csM && !dmem_ready);
      end
    end
    if (rst) begin
      init_left = IC;
      waiting   = 0;
      sc        = 0;
      fc        = 0;
      valid     = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, b, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 16'({stall_F, stall_D, stall_E, stall_M}), 16'(e.st));
        chk("flush", 16'({flush_D, flush_E}), 16'(e.fl));
        chk("fwd", 16'({fwd_a, fwd_b}), 16'(e.fw));
        chk("stall_cnt", 16'(stall_cnt), 16'(e.sc));
        chk("flush_cnt", 16'(flush_cnt), 16'(e.fc));
      end
    end
  end

  initial begin
    int n;
    clr();
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    repeat (4) cyc();
    reg_wrM = 1; rd_M = 5; rs1_E = 5; reg_wrW = 1; rd_W = 5; rs2_E = 5;
    cyc();
    rd_M = 0;
    cyc();
    clr();
    rdE = 1; rd_E = 7; rs2_D = 7;
    cyc();
    rdE = 0;
    cyc();
    rdE = 1; rd_E = 0;
    cyc();
    clr();
    rdE = 1; rd_E = 7; rs2_D = 7; br_takenE = 1;
    cyc();
    clr();
    csM = 1; dmem_ready = 0; br_takenE = 1;
    repeat (3) cyc();
    dmem_ready = 1;
    cyc();
    csM = 0;
    cyc();
    clr();
    cyc();
    reg_wrE = 1; rd_E = 3; rs1_D = 3;
    cyc();
    reg_wrE = 0; rd_E = 0; reg_wrM = 1; rd_M = 3;
    cyc();
    reg_wrM = 0; rd_M = 0; reg_wrW = 1; rd_W = 3;
    cyc();
    clr();
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst        = $urandom_range(0, 199) == 0;
      rs1_D      = 5'($urandom_range(0, 7));
      rs2_D      = 5'($urandom_range(0, 7));
      rs1_E      = 5'($urandom_range(0, 7));
      rs2_E      = 5'($urandom_range(0, 7));
      rd_E       = 5'($urandom_range(0, 7));
      rd_M       = 5'($urandom_range(0, 7));
      rd_W       = 5'($urandom_range(0, 7));
      reg_wrE    = 1'($urandom_range(0, 1));
      reg_wrM    = 1'($urandom_range(0, 1));
      reg_wrW    = 1'($urandom_range(0, 1));
      rdE        = $urandom_range(0, 2) == 0;
      csM        = $urandom_range(0, 4) == 0;
      br_takenE  = $urandom_range(0, 5) == 0;
      dmem_ready = $urandom_range(0, 9) < 7;
      cyc();
    end
    rst = 0;
    clr();
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
